// File: rtl/intra4x4_mode_decision_pkg.sv
// Shared types and constants for the intra-4x4 mode decision slice.
package intra4x4_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SAD_W  = 12;
  localparam int unsigned COST_W = 13;

  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef enum logic [3:0] {
    VERT = 4'd0,
    HORZ = 4'd1,
    DC   = 4'd2,
    DDL  = 4'd3,
    DDR  = 4'd4,
    VR   = 4'd5,
    HD   = 4'd6,
    VL   = 4'd7,
    HU   = 4'd8
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Clamp a wide unsigned sum to the cost range.
  function automatic logic [COST_W-1:0] sat_cost(input logic [31:0] v);
    return (v > 32'(COST_MAX)) ? COST_MAX : v[COST_W-1:0];
  endfunction

endpackage

// File: rtl/intra4x4_mode_decision_if.sv
// Candidate stream, block setup and result bus of the mode decision block.
interface intra4x4_mode_decision_if #(
  parameter int unsigned LAMBDA_W = 8
);
  import intra4x4_pkg::*;

  logic                  start;
  logic [16*PIX_W-1:0]   orig;
  logic                  pred_valid;
  logic                  pred_ready;
  logic [3:0]            pred_mode;
  logic [16*PIX_W-1:0]   pred;
  logic                  pred_last;
  logic [3:0]            mpm;
  logic [LAMBDA_W-1:0]   lambda;
  logic                  done;
  logic [3:0]            best_mode;
  logic [COST_W-1:0]     best_cost;

  modport master (
    output start, orig, pred_valid, pred_mode, pred, pred_last, mpm, lambda,
    input  pred_ready, done, best_mode, best_cost
  );

  modport slave (
    input  start, orig, pred_valid, pred_mode, pred, pred_last, mpm, lambda,
    output pred_ready, done, best_mode, best_cost
  );

endinterface

// File: rtl/intra4x4_mode_decision_sad4x4.sv
// sad4x4: registered 16-sample absolute difference followed by a registered sum.
module sad4x4
  import intra4x4_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [16*PIX_W-1:0] orig,
  input  logic [16*PIX_W-1:0] pred,
  output logic                out_valid,
  output logic [SAD_W-1:0]    sad
);

  logic [PIX_W-1:0] ad_c [16];
  logic [PIX_W-1:0] ad_q [16];
  logic             v1_q;
  logic [SAD_W-1:0] sum_c;

  // Per-sample absolute difference.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      ad_c[i] = (orig[8*i +: 8] > pred[8*i +: 8]) ? orig[8*i +: 8] - pred[8*i +: 8]
                                                   : pred[8*i +: 8] - orig[8*i +: 8];
    end
  end

  // Stage 1: capture the differences of an accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) ad_q[i] <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < 16; i++) ad_q[i] <= ad_c[i];
      end
    end
  end

  // Sum of the 16 differences; 16*255 fits in 12 bits.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < 16; i++) sum_c = sum_c + SAD_W'(ad_q[i]);
  end

  // Stage 2: register the SAD and its valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      sad       <= '0;
    end else begin
      out_valid <= v1_q;
      sad       <= sum_c;
    end
  end

endmodule

// File: rtl/intra4x4_mode_decision.sv
// intra4x4_mode_decision: picks the lowest-cost intra-4x4 candidate of a block.
// Optional macro INTRA4X4_MODE_COST_EN adds 4*lambda to non-MPM candidates.
module intra4x4_mode_decision
  import intra4x4_pkg::*;
#(
  parameter int unsigned LAMBDA_W = 8
) (
  input logic                      clk,
  input logic                      reset,
  intra4x4_mode_decision_if.slave  bus
);

`ifdef INTRA4X4_MODE_COST_EN
  localparam bit COST_EN = 1'b1;
`else
  localparam bit COST_EN = 1'b0;
`endif

  state_t              state;
  logic                drain_cnt;
  logic [16*PIX_W-1:0] orig_q;
  logic                first_q;
  logic                accept;
  logic [3:0]          s1_mode, s2_mode;
  logic [31:0]         pen_c, s2_pen;
  logic                s2_valid;
  logic [SAD_W-1:0]    s2_sad;
  logic [COST_W-1:0]   cost_c;
  logic [3:0]          best_mode_q;
  logic [COST_W-1:0]   best_cost_q;
  logic                done_q;
  logic [LAMBDA_W-1:0] lam;

  assign lam            = bus.lambda;
  assign accept         = bus.pred_valid && (state == COLLECT);
  assign bus.pred_ready = (state == COLLECT);
  assign bus.done       = done_q;
  assign bus.best_mode  = best_mode_q;
  assign bus.best_cost  = best_cost_q;

  sad4x4 u_sad (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .orig      (orig_q),
    .pred      (bus.pred),
    .out_valid (s2_valid),
    .sad       (s2_sad)
  );

  // Block sequencing: collect candidates, drain the pipeline, report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= COLLECT;
        COLLECT: if (accept && bus.pred_last) begin
                   state     <= DRAIN;
                   drain_cnt <= 1'b0;
                 end
        DRAIN:   if (drain_cnt) state <= DONE;
                 else           drain_cnt <= 1'b1;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Mode-cost term; folds to zero when the cost feature is compiled out.
  always_comb begin
    pen_c = '0;
    if (COST_EN && (s1_mode != bus.mpm)) pen_c = 32'(lam) << 2;
  end

  // Mode and mode-cost travel alongside the SAD pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_mode <= '0;
      s2_mode <= '0;
      s2_pen  <= '0;
    end else begin
      s1_mode <= bus.pred_mode;
      s2_mode <= s1_mode;
      s2_pen  <= pen_c;
    end
  end

  assign cost_c = sat_cost(32'(s2_sad) + s2_pen);

  // Stage 3 running best; start re-arms the first-candidate load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      orig_q      <= '0;
      first_q     <= 1'b0;
      best_mode_q <= '0;
      best_cost_q <= '0;
    end else begin
      if (s2_valid) begin
        if (first_q || (cost_c < best_cost_q)) begin
          best_mode_q <= s2_mode;
          best_cost_q <= cost_c;
        end
        first_q <= 1'b0;
      end
      if ((state == IDLE) && bus.start) begin
        orig_q  <= bus.orig;
        first_q <= 1'b1;
      end
    end
  end

  // Result strobe one cycle after the DONE state, once stage 3 has settled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= (state == DONE);
  end

endmodule

// File: doc/intra4x4_mode_decision.md
INTRA4X4_MODE_DECISION -- requirements
Module: intra4x4_mode_decision

Interface
REQ-001: Parameter LAMBDA_W, default 8, width of the lambda input.
REQ-002: clk  in  1  rising-edge clock for all state.
REQ-003: reset  in  1  asynchronous, active-low reset.
REQ-004: start  in  1  one-cycle pulse that opens a decision for a new 4x4 block.
REQ-005: orig  in  128  original block, sample n at bits [8n+7:8n], raster order a..p.
REQ-006: pred_valid  in  1  candidate beat valid.
REQ-007: pred_ready  out  1  block accepts a candidate beat.
REQ-008: pred_mode  in  4  H.264 intra-4x4 mode of the candidate, 0..8.
REQ-009: pred  in  128  predicted samples, same packing as orig.
REQ-010: pred_last  in  1  marks the final candidate of the block.
REQ-011: mpm  in  4  most probable mode.
REQ-012: lambda  in  LAMBDA_W  mode-cost weight.
REQ-013: done  out  1  one-cycle result strobe.
REQ-014: best_mode  out  4  winning mode.
REQ-015: best_cost  out  13  winning cost.

Function
REQ-016: States are IDLE, COLLECT, DRAIN and DONE.
- IDLE -> COLLECT on start.
- COLLECT -> DRAIN on an accepted beat with pred_last=1.
- DRAIN -> DONE after 2 cycles.
- DONE -> IDLE after 1 cycle.
REQ-017: pred_ready is high only in COLLECT; a beat is accepted on a rising edge with pred_valid and pred_ready both high.
REQ-018: orig is captured on the start edge and held for the whole decision.
REQ-019: Pipeline for each accepted beat:
- Stage 1 registers the 16 absolute differences |orig-pred|.
- Stage 2 registers SAD, 12 bits unsigned, maximum 4080, plus the mode cost.
- Stage 3 compares the cost against the running best.
REQ-020: Cost is computed with 13-bit unsigned saturation at 8191.
REQ-021: The first candidate of a block always loads the best register; later candidates replace it only if their cost is strictly lower, so the earlier candidate wins a tie.
REQ-022: done rises 3 cycles after the accepting edge of the pred_last beat; best_mode and best_cost are valid while done is high and are held until the next start.
REQ-023: Back-to-back beats, one per cycle, are accepted without stall; pred_valid gaps are allowed.
REQ-024: start outside IDLE is ignored; pred_valid outside COLLECT is ignored.
REQ-025: pred_mode values greater than 8 are accepted and costed as given, with no error flag.

Reset
REQ-026: Asserting reset at any time, including mid-block, forces the following on the asynchronous edge:
- state to IDLE;
- pred_ready=0, done=0;
- best_mode=0, best_cost=0;
- pipeline valid bits cleared.
REQ-027: After reset release the block needs a fresh start; partial results are discarded.

Configuration
REQ-028: Macro INTRA4X4_MODE_COST_EN.
- When defined, cost = SAD + 4*lambda if pred_mode != mpm, else cost = SAD.
- When undefined, cost = SAD zero-extended to 13 bits; mpm and lambda remain as ports but are ignored.

Structure
REQ-029: Package intra4x4_pkg holds the following:
- the mode enum: VERT=0, HORZ=1, DC=2, DDL=3, DDR=4, VR=5, HD=6, VL=7, HU=8;
- constants PIX_W=8, SAD_W=12, COST_W=13;
- the state enum.
REQ-030: Sub-module sad4x4 implements stages 1-2, i.e. the abs-diff array plus a registered adder tree, with a valid pass-through.

Verification
REQ-031: orig all 100; candidates mode0 pred all 100, mode1 all 101, last = mode1 -> done with best_mode=0, best_cost=0.
REQ-032: orig all 0; modes 2,6 both pred all 10, cost 160 each, macro off -> best_mode=2 (tie keeps first).
REQ-033: Macro on; mpm=6, lambda=10; mode2 SAD=100, mode6 SAD=130 -> mode2 cost 140, mode6 cost 130 -> best_mode=6, best_cost=130.
REQ-034: orig all 255, pred all 0, single beat with last -> best_cost=4080; done exactly 3 cycles after the accept edge.
REQ-035: Nine beats back-to-back with pred_valid held high -> pred_ready stays high through all nine; one done pulse; start pulsed during DRAIN is ignored.
REQ-036: reset driven low after 3 beats of a block -> outputs 0 and state IDLE immediately; the next start with 1 beat (SAD 48) -> best_cost=48, with no carry-over from the aborted block.
